// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
// Includes state encodings, winner codes, score width and a saturating score increment.
package pong_pkg;

  localparam int unsigned SCORE_W = 4;

  typedef logic [2:0] match_state_t;

  localparam match_state_t StIdle     = 3'd0;
  localparam match_state_t StServe    = 3'd1;
  localparam match_state_t StRally    = 3'd2;
  localparam match_state_t StPoint    = 3'd3;
  localparam match_state_t StGameOver = 3'd4;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    return (v >= lim) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Game-flow signals between buttons/image logic and the match controller.
// The ctrl modport is used by pong_match_ctrl; the host modport by whoever drives it.
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic               frame_tick;
  logic               start_game;
  logic               goal_p1;
  logic               goal_p2;
  logic               paddle_hit;
  logic [1:0]         ball_speed;
  logic               ball_run;
  logic               ball_rst;
  logic               serve_dir;
  logic [1:0]         speed_sel;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               flash;
  logic [1:0]         winner;
  logic [2:0]         state_o;

  modport ctrl (
    input  frame_tick, start_game, goal_p1, goal_p2, paddle_hit, ball_speed,
    output ball_run, ball_rst, serve_dir, speed_sel, score1, score2, flash, winner, state_o
  );

  modport host (
    output frame_tick, start_game, goal_p1, goal_p2, paddle_hit, ball_speed,
    input  ball_run, ball_rst, serve_dir, speed_sel, score1, score2, flash, winner, state_o
  );

endinterface

// File: rtl/pong_frame_timer.sv
// Frame-tick counter with clear and terminal-count compare, plus a flash output
// that toggles every 8 frame ticks while enabled.
module pong_frame_timer #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_i,
  input  logic            clear_i,
  input  logic [CntW-1:0] term_i,
  input  logic            flash_en_i,
  output logic            done_o,
  output logic            flash_o
);

  logic [CntW-1:0] cnt_q;
  logic [2:0]      fcnt_q;
  logic            flash_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !flash_en_i) begin
      fcnt_q  <= '0;
      flash_q <= 1'b0;
    end else if (tick_i) begin
      fcnt_q <= fcnt_q + 3'd1;
      if (fcnt_q == 3'd7) flash_q <= ~flash_q;
    end
  end

  // A tick in the clearing cycle is the state-entry tick and never terminates.
  assign done_o  = tick_i && !clear_i && (cnt_q == term_i - CntW'(1));
  assign flash_o = flash_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: idle/serve/rally/point/game-over, scores, winner and ball speed.
// Define PONG_SPEED_RAMP_EN to raise speed_sel every RAMP_HITS paddle hits in a rally.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned RAMP_HITS    = 4
) (
  input logic          clk,
  input logic          reset,
  pong_match_ctrl_if.ctrl bus
);

  localparam int unsigned MaxFrames = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES
                                                                      : POINT_FRAMES;
  localparam int unsigned CntW = $clog2(MaxFrames + 1);
  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

  match_state_t       state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               start_q, entry_q;
  logic [1:0]         speed_q;
  logic               start_rise, goal_any, timer_done, flash;
  logic [CntW-1:0]    term;

  assign start_rise = bus.start_game & ~start_q;
  assign goal_any   = bus.goal_p1 | bus.goal_p2;
  assign term       = (state_q == StPoint) ? CntW'(POINT_FRAMES) : CntW'(SERVE_FRAMES);

  pong_frame_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (bus.frame_tick),
    .clear_i    (entry_q),
    .term_i     (term),
    .flash_en_i ((state_q == StPoint) || (state_q == StGameOver)),
    .done_o     (timer_done),
    .flash_o    (flash)
  );

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    case (state_q)
      StIdle, StGameOver: begin
        if (start_rise) begin
          state_d  = StServe;
          score1_d = '0;
          score2_d = '0;
          winner_d = WinNone;
        end
      end
      StServe: begin
        if (timer_done) state_d = StRally;
      end
      StRally: begin
        if (bus.goal_p1 && bus.goal_p2) begin
          state_d = StPoint;
        end else if (bus.goal_p1) begin
          state_d     = StPoint;
          score1_d    = sat_inc(score1_q, WinScore);
          serve_dir_d = 1'b1;
        end else if (bus.goal_p2) begin
          state_d     = StPoint;
          score2_d    = sat_inc(score2_q, WinScore);
          serve_dir_d = 1'b0;
        end
      end
      StPoint: begin
        if (timer_done) begin
          if (score1_q == WinScore) begin
            state_d  = StGameOver;
            winner_d = WinP1;
          end else if (score2_q == WinScore) begin
            state_d  = StGameOver;
            winner_d = WinP2;
          end else begin
            state_d = StServe;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= WinNone;
      serve_dir_q <= 1'b1;
      start_q     <= 1'b0;
      entry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      start_q     <= bus.start_game;
      entry_q     <= (state_d != state_q);
    end
  end

`ifdef PONG_SPEED_RAMP_EN
  localparam int unsigned HitW = (RAMP_HITS > 1) ? $clog2(RAMP_HITS) : 1;

  logic [HitW-1:0] hit_cnt_q, hit_cnt_d;
  logic [1:0]      speed_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    speed_d   = speed_q;
    if ((state_q == StIdle) || ((state_d == StServe) && (state_q != StServe))) begin
      hit_cnt_d = '0;
      speed_d   = bus.ball_speed;
    end else if ((state_q == StRally) && bus.paddle_hit && !goal_any) begin
      // A goal in the same cycle ends the rally, so that hit does not count.
      if (hit_cnt_q == HitW'(RAMP_HITS - 1)) begin
        hit_cnt_d = '0;
        speed_d   = (speed_q == 2'b11) ? speed_q : speed_q + 2'd1;
      end else begin
        hit_cnt_d = hit_cnt_q + HitW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q <= '0;
      speed_q   <= bus.ball_speed;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      speed_q   <= speed_d;
    end
  end
`else
  localparam int unsigned UnusedRampHits = RAMP_HITS;
  logic unused_hit;
  assign unused_hit = bus.paddle_hit ^ goal_any;

  always_ff @(posedge clk) begin
    speed_q <= bus.ball_speed;
  end
`endif

  assign bus.ball_run  = (state_q == StRally);
  assign bus.ball_rst  = (state_q != StRally);
  assign bus.serve_dir = serve_dir_q;
  assign bus.speed_sel = speed_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.flash     = flash;
  assign bus.winner    = winner_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE = 3; inputs change and outputs
// are sampled on the falling clock edge.
module tb_pong_match_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (60),
    .POINT_FRAMES (90),
    .RAMP_HITS    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Three quiet cycles then one tick cycle; returns on the negedge after the tick edge.
  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b0;
      cyc(3);
      bus.frame_tick = 1'b1;
      cyc(1);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic goal(input logic g1, input logic g2);
    bus.goal_p1 = g1;
    bus.goal_p2 = g2;
    cyc(1);
    bus.goal_p1 = 1'b0;
    bus.goal_p2 = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_game = 1'b1;
    cyc(1);
    bus.start_game = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start_game = 1'b0;
    bus.goal_p1    = 1'b0;
    bus.goal_p2    = 1'b0;
    bus.paddle_hit = 1'b0;
    bus.ball_speed = 2'b01;
    cyc(3);
    reset = 1'b0;
    tick_frames(3);

    check_eq("rst_state", int'(bus.state_o), 0);
    check_eq("rst_score1", int'(bus.score1), 0);
    check_eq("rst_score2", int'(bus.score2), 0);
    check_eq("rst_ball_rst", int'(bus.ball_rst), 1);
    check_eq("rst_ball_run", int'(bus.ball_run), 0);
    check_eq("rst_winner", int'(bus.winner), 0);
    check_eq("rst_serve_dir", int'(bus.serve_dir), 1);
    check_eq("rst_flash", int'(bus.flash), 0);
    check_eq("rst_speed", int'(bus.speed_sel), 1);

    // Held button gives exactly one start.
    bus.start_game = 1'b1;
    cyc(1);
    check_eq("start_serve", int'(bus.state_o), 1);
    cyc(9);
    bus.start_game = 1'b0;
    check_eq("start_held_serve", int'(bus.state_o), 1);

    tick_frames(59);
    check_eq("serve_59_run", int'(bus.ball_run), 0);
    tick_frames(1);
    check_eq("serve_60_run", int'(bus.ball_run), 1);
    check_eq("serve_60_state", int'(bus.state_o), 2);

    // Point 1: player 1 scores.
    cyc(2);
    goal(1'b1, 1'b0);
    check_eq("p1_score1", int'(bus.score1), 1);
    check_eq("p1_serve_dir", int'(bus.serve_dir), 1);
    check_eq("p1_state", int'(bus.state_o), 3);
    check_eq("p1_ball_rst", int'(bus.ball_rst), 1);
    tick_frames(7);
    check_eq("flash_7", int'(bus.flash), 0);
    tick_frames(1);
    check_eq("flash_8", int'(bus.flash), 1);
    pulse_start();
    goal(1'b0, 1'b1);
    check_eq("point_goal_ign", int'(bus.score2), 0);
    tick_frames(81);
    check_eq("point_89_state", int'(bus.state_o), 3);
    tick_frames(1);
    check_eq("point_90_state", int'(bus.state_o), 1);
    goal(1'b0, 1'b1);
    check_eq("serve_goal_ign", int'(bus.score2), 0);
    tick_frames(60);

    // Point 2: player 2 scores.
    goal(1'b0, 1'b1);
    check_eq("p2_score2", int'(bus.score2), 1);
    check_eq("p2_serve_dir", int'(bus.serve_dir), 0);
    tick_frames(90);
    tick_frames(60);

    // Point 3: let.
    goal(1'b1, 1'b1);
    check_eq("let_state", int'(bus.state_o), 3);
    check_eq("let_score1", int'(bus.score1), 1);
    check_eq("let_score2", int'(bus.score2), 1);
    check_eq("let_serve_dir", int'(bus.serve_dir), 0);
    tick_frames(90);
    tick_frames(60);

    // Points 4 and 5: player 2 reaches 3.
    goal(1'b0, 1'b1);
    check_eq("p4_score2", int'(bus.score2), 2);
    tick_frames(90);
    tick_frames(60);
    goal(1'b0, 1'b1);
    check_eq("p5_score2", int'(bus.score2), 3);
    tick_frames(89);
    check_eq("p5_89_state", int'(bus.state_o), 3);
    tick_frames(1);
    check_eq("gameover_state", int'(bus.state_o), 4);
    check_eq("gameover_winner", int'(bus.winner), 2);
    check_eq("gameover_run", int'(bus.ball_run), 0);
    goal(1'b1, 1'b0);
    cyc(1);
    check_eq("gameover_goal_ign", int'(bus.score1), 1);

    pulse_start();
    check_eq("restart_state", int'(bus.state_o), 1);
    check_eq("restart_score1", int'(bus.score1), 0);
    check_eq("restart_score2", int'(bus.score2), 0);
    check_eq("restart_winner", int'(bus.winner), 0);

    tick_frames(60);
    check_eq("rally2_state", int'(bus.state_o), 2);
    for (int i = 0; i < 4; i++) begin
      bus.paddle_hit = 1'b1;
      cyc(1);
      bus.paddle_hit = 1'b0;
      cyc(1);
    end
`ifdef PONG_SPEED_RAMP_EN
    check_eq("ramp_4", int'(bus.speed_sel), 2);
`else
    check_eq("noramp_4", int'(bus.speed_sel), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      bus.paddle_hit = 1'b1;
      cyc(1);
      bus.paddle_hit = 1'b0;
      cyc(1);
    end
`ifdef PONG_SPEED_RAMP_EN
    check_eq("ramp_8", int'(bus.speed_sel), 3);
`else
    check_eq("noramp_8", int'(bus.speed_sel), 1);
    bus.ball_speed = 2'b10;
    cyc(1);
    check_eq("speed_follow", int'(bus.speed_sel), 2);
    bus.ball_speed = 2'b01;
    cyc(1);
`endif

    // Reset mid-rally.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check_eq("midrst_state", int'(bus.state_o), 0);
    check_eq("midrst_speed", int'(bus.speed_sel), 1);
    check_eq("midrst_ball_rst", int'(bus.ball_rst), 1);
    check_eq("midrst_serve_dir", int'(bus.serve_dir), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Game-flow sequencer for the VGA pong/foosball design.
- Owns the match state machine (idle, serve, rally, point, game over), the two player scores and the ball-speed selection.
- Tells the ball/paddle image logic when the ball may move, when to recentre it, and which way to serve.
- Sits between the top-level buttons/switches and the image generator; its scores feed the 7-segment score display.

Parameters:
- WIN_SCORE, 9, points needed to win the match; range 1..9, fits one 7-seg digit.
- SERVE_FRAMES, 60, frames the ball is held centred before each serve.
- POINT_FRAMES, 90, frames of post-goal pause; the scorer's side flashes.
- RAMP_HITS, 4, paddle hits per speed step (SPEED_RAMP_EN only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse at start of each frame (Vsync edge, already synchronised to clk).
- start_game  in  1  level from push button; rising edge detected internally.
- goal_p1  in  1  one-cycle pulse: ball left via player-2 side, so player 1 scores.
- goal_p2  in  1  one-cycle pulse: player 2 scores.
- paddle_hit  in  1  one-cycle pulse per paddle contact.
- ball_speed  in  2  switch-selected base speed.
- ball_run  out  1  ball may move.
- ball_rst  out  1  hold ball at centre.
- serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2.
- speed_sel  out  2  ball clock select into the existing speed mux.
- score1  out  4  player-1 score, 0..WIN_SCORE.
- score2  out  4  player-2 score, 0..WIN_SCORE.
- flash  out  1  toggles every 8 frames in POINT and GAME_OVER, else 0.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE; score1 = score2 = 0; winner = 00; serve_dir = 1; flash = 0.
  - ball_run = 0; ball_rst = 1; speed_sel = ball_speed.
  - Frame counter, hit counter and edge register all 0.
- Reset asserted mid-operation behaves exactly like power-up reset: no partial score retention.
- start_game edge detection: start_rise = start_game & ~start_q, one-cycle; start_q is registered every cycle.
- IDLE:
  - ball_rst = 1, ball_run = 0.
  - start_rise -> SERVE; scores cleared; frame counter cleared.
- SERVE:
  - ball_rst = 1, ball_run = 0.
  - Counts frame_tick; on the SERVE_FRAMES-th tick -> RALLY.
  - Goals and hits ignored.
- RALLY:
  - ball_rst = 0, ball_run = 1.
  - goal_p1 alone -> score1 + 1, serve_dir = 1, -> POINT.
  - goal_p2 alone -> score2 + 1, serve_dir = 0, -> POINT.
  - Score update and state change are registered: a goal in cycle n is visible in cycle n+1.
  - goal_p1 and goal_p2 in the same cycle -> no score change, serve_dir unchanged, -> POINT (let).
- POINT:
  - ball_run = 0, ball_rst = 1.
  - After POINT_FRAMES ticks: if either score == WIN_SCORE -> GAME_OVER, winner set; else -> SERVE.
- GAME_OVER:
  - ball_run = 0, ball_rst = 1; scores frozen; flash active.
  - start_rise -> SERVE with scores and winner cleared.
- Timing and counter rules:
  - Frame counters reset to 0 on every state entry; frame_tick on the entry cycle is not counted.
  - Score arithmetic is 4-bit and saturates at WIN_SCORE; increments never wrap.
  - Goals outside RALLY are ignored.
- start_rise in SERVE, RALLY or POINT is ignored.
- Without the optional feature, speed_sel = ball_speed, registered with 1-cycle latency.

Optional Feature:
- Macro: PONG_SPEED_RAMP_EN.
- With it defined:
  - Hit counter counts paddle_hit in RALLY only.
  - Every RAMP_HITS hits, speed_sel increments, saturating at 3.
  - Counter and speed_sel reload from ball_speed on SERVE entry.
  - A simultaneous hit and goal: the goal wins and the hit is discarded.
- Without it: no hit counter; paddle_hit is unused; speed_sel follows ball_speed.

Decomposition:
- Package pong_pkg holds:
  - match_state_t enum: IDLE = 0, SERVE = 1, RALLY = 2, POINT = 3, GAME_OVER = 4.
  - SCORE_W = 4.
  - winner encoding constants.
- One sub-module, pong_frame_timer: loadable frame_tick counter with clear, terminal-count compare and flash-toggle output.
  - Instantiated once and shared by SERVE and POINT.

Test Plan:
- Reset, then 3 frames idle -> state IDLE, score1 = score2 = 0, ball_rst = 1, ball_run = 0, winner = 00.
- start_game held high 10 cycles -> one transition to SERVE only; after 60 frame_ticks, ball_run = 1 the next cycle.
- In RALLY, pulse goal_p1 -> score1 = 1 next cycle, serve_dir = 1, POINT; after 90 ticks, SERVE.
- goal_p1 and goal_p2 in the same cycle -> scores unchanged, state POINT.
- With WIN_SCORE = 3, player 2 scores 3 times -> GAME_OVER, winner = 10, further goals ignored; start_game -> scores 0, SERVE.
- PONG_SPEED_RAMP_EN, ball_speed = 01, 8 paddle_hits -> speed_sel = 11; reset mid-RALLY -> IDLE, speed_sel = 01.
